// File: rtl/fetch_queue_if.sv
// Fetch queue bus: PC handshake, instruction memory port, decode port.
// master is the fetch queue side, slave is the surrounding pipeline/memory.
interface fetch_queue_if;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        err_spurious;

    modport master (
        input  pc_in, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        output pc_en, imem_req, imem_addr, id_valid, id_instr, id_pc,
               err_spurious
    );

    modport slave (
        output pc_in, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        input  pc_en, imem_req, imem_addr, id_valid, id_instr, id_pc,
               err_spurious
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order tagging,
// flush with stale-response dropping, decode-side valid/ready queue.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int MAX_OS = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int QW = $clog2(DEPTH);
    localparam int AW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW:0]   MAXOS_C = (CW + 1)'(MAX_OS);
    localparam logic [AW-1:0] ALAST   = AW'(MAX_OS - 1);

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   a_fifo  [MAX_OS];
    logic [QW-1:0] q_rd, q_wr;
    logic [AW-1:0] a_rd, a_wr;
    logic [CW-1:0] occ, os, drop;
    logic          err;

    logic credit_ok, req, accept;
    logic rsp_drop, rsp_live, rsp_spur;
    logic q_push, q_pop, valid;

    function automatic logic [AW-1:0] a_inc(input logic [AW-1:0] p);
        return (p == ALAST) ? '0 : p + 1'b1;
    endfunction

    // Request credits, response classification and queue handshakes.
    always_comb begin
        credit_ok = (({1'b0, os} + {1'b0, drop}) < MAXOS_C)
                 && (({1'b0, occ} + {1'b0, os}) < DEPTH_C);
        req      = !rst && !bus.flush && credit_ok;
        accept   = req && bus.imem_gnt;
        rsp_drop = bus.imem_rvalid && (drop != '0);
        rsp_live = bus.imem_rvalid && (drop == '0) && (os != '0);
        rsp_spur = bus.imem_rvalid && (drop == '0) && (os == '0);
        valid    = !rst && !bus.flush && (occ != '0);
        q_push   = rsp_live && !bus.flush;
        q_pop    = valid && bus.id_ready;
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = bus.pc_in;
    assign bus.pc_en        = accept;
    assign bus.id_valid     = valid;
    assign bus.id_instr     = rst ? '0 : q_instr[q_rd];
    assign bus.id_pc        = rst ? '0 : q_pc[q_rd];
    assign bus.err_spurious = err;

    // Counters and pointers; flush moves live outstanding into drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= '0;
            os   <= '0;
            drop <= '0;
            q_rd <= '0;
            q_wr <= '0;
            a_rd <= '0;
            a_wr <= '0;
            err  <= 1'b0;
        end else begin
            err <= err | rsp_spur;
            if (bus.flush) begin
                occ  <= '0;
                os   <= '0;
                drop <= drop + os - CW'(rsp_drop | rsp_live);
                q_rd <= '0;
                q_wr <= '0;
                a_rd <= '0;
                a_wr <= '0;
            end else begin
                occ  <= occ + CW'(q_push) - CW'(q_pop);
                os   <= os + CW'(accept) - CW'(rsp_live);
                drop <= drop - CW'(rsp_drop);
                if (q_push) q_wr <= q_wr + 1'b1;
                if (q_pop) q_rd <= q_rd + 1'b1;
                if (accept) a_wr <= a_inc(a_wr);
                if (rsp_live) a_rd <= a_inc(a_rd);
            end
        end
    end

    // Storage: request address tags and tagged instructions.
    always_ff @(posedge clk) begin
        if (accept) a_fifo[a_wr] <= bus.pc_in;
        if (q_push) begin
            q_instr[q_wr] <= bus.imem_rdata;
            q_pc[q_wr]    <= a_fifo[a_rd];
        end
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 Parameter MAX_OS, default 2, max outstanding imem requests (1..DEPTH).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_in  input  32  current fetch address from PC register.
REQ-006 pc_en  output  1  PC advance enable; PC register loads next address at next posedge.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address.
REQ-009 imem_gnt  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  response valid, responses return in request order.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 flush  input  1  redirect from branch/jump; discard all fetched/in-flight instructions.
REQ-013 id_valid  output  1  decode-side instruction valid.
REQ-014 id_ready  input  1  decode stage accepts instruction.
REQ-015 id_instr  output  32  instruction at queue head.
REQ-016 id_pc  output  32  address of id_instr.
REQ-017 err_spurious  output  1  sticky flag: response received with nothing outstanding.

Function
REQ-018 Counters: occ (queue occupancy, 0..DEPTH), os (live outstanding, 0..MAX_OS), drop (stale outstanding to discard, 0..MAX_OS).
REQ-019 imem_req SHALL be 1 iff !flush and os+drop < MAX_OS and occ+os < DEPTH; imem_addr SHALL equal pc_in combinationally.
REQ-020 Request accepted when imem_req & imem_gnt; in that cycle pc_en SHALL be 1, otherwise 0.
REQ-021 Each accepted request SHALL push pc_in into an in-order address FIFO (MAX_OS deep) used to tag its response.
REQ-022 imem_req SHALL stay asserted with stable imem_addr until granted unless flush or credit rules drop it.
REQ-023 On imem_rvalid with drop>0: drop decrements, response discarded, no queue write.
REQ-024 On imem_rvalid with drop==0 and os>0: {address FIFO head, imem_rdata} written to queue, os decrements, address FIFO pops.
REQ-025 On imem_rvalid with os==0 and drop==0: response ignored, err_spurious set to 1 until reset.
REQ-026 id_valid = (occ>0) & !flush; id_instr/id_pc = queue head; pop on id_valid & id_ready.
REQ-027 Latency: request granted cycle N, earliest rvalid N+1, id_valid earliest N+2 (queue write registered).
REQ-028 Simultaneous push and pop SHALL leave occ unchanged; credit rule REQ-019 guarantees no overflow; push to full queue is a design error.
REQ-029 Grant and response in same cycle: os updates by +1-1 (net 0); address FIFO push/pop both applied.
REQ-030 Flush cycle: imem_req=0, pc_en=0, id_valid=0; at posedge occ<=0, drop<=drop+os-(rvalid consumed this cycle), os<=0, address FIFO cleared; rvalid in flush cycle SHALL be discarded.
REQ-031 Operation after flush: requests resume next cycle from new pc_in subject to REQ-019 (drop counts against MAX_OS).
REQ-032 Pointers wrap modulo DEPTH / MAX_OS without bubble.

Reset
REQ-033 rst asserted: occ=0, os=0, drop=0, pointers=0, err_spurious=0 immediately, no clock required.
REQ-034 During reset imem_req=0, pc_en=0, id_valid=0; id_instr/id_pc SHALL read 0.
REQ-035 Reset mid-transaction: in-flight responses arriving after release with os==0 set err_spurious (memory also reset by system).
REQ-036 First request SHALL be issued in first cycle after rst deasserts, addr=pc_in.

Verification
REQ-037 gnt=1 always, 1-cycle memory, id_ready=1, pc_in 0x0,0x4,0x8 -> id_pc 0x0,0x4,0x8 on consecutive cycles from cycle 2, id_instr matches memory.
REQ-038 id_ready=0 held -> occ reaches 4, imem_req drops to 0, pc_en 0; id_ready=1 -> 4 entries drain in order, requests resume.
REQ-039 Two outstanding (0x10,0x14), flush asserted with pc_in=0x100 -> both responses discarded, next id_pc=0x100.
REQ-040 gnt=0 for 3 cycles -> imem_req stays 1, imem_addr stable, pc_en=0 throughout.
REQ-041 rvalid with nothing outstanding -> err_spurious=1, queue unchanged; rst pulse -> err_spurious=0 asynchronously.
REQ-042 rst asserted mid-stream between clock edges -> id_valid and imem_req fall to 0 immediately.
